// File: rtl/hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: load-use and mul/div stalls,
// operand forwarding selects for the D, E and M stages.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tuse_rs0,
  input  logic       tuse_rs1,
  input  logic       tuse_rt0,
  input  logic       tuse_rt1,
  input  logic       tuse_rt2,
  input  logic [4:0] a1_d,
  input  logic [4:0] a2_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] res_d,
  input  logic       md_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC8 = 2'b11
  } res_t;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    res_t       res;
  } e_t;

  typedef struct packed {
    logic [4:0] a2;
    logic [4:0] a3;
    res_t       res;
  } m_t;

  typedef struct packed {
    logic [4:0] a3;
    res_t       res;
  } w_t;

  e_t         e_q;
  m_t         m_q;
  w_t         w_q;
  e_t         d_in;
  logic [3:0] md_cnt;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  function automatic logic writes(
    input logic [4:0] a3,
    input res_t       res,
    input logic [4:0] r
  );
    return (a3 == r) && (r != 5'd0) && (res != RES_NW);
  endfunction

  function automatic logic [1:0] tnew_e(input res_t res);
    unique case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input res_t res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // Stall when a producer's result is ready later than the consumer's
  // earliest use; tuse = 3 means the operand is not read at all.
  function automatic logic hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input e_t         e,
    input m_t         m
  );
    logic e_hit;
    logic m_hit;
    e_hit = writes(e.a3, e.res, r) && (tnew_e(e.res) > tuse);
    m_hit = writes(m.a3, m.res, r) && (tnew_m(m.res) > tuse);
    return e_hit || m_hit;
  endfunction

  function automatic logic [1:0] sel_d(
    input logic [4:0] r,
    input e_t         e,
    input m_t         m,
    input w_t         w
  );
    if (writes(e.a3, e.res, r) && (e.res == RES_PC8))
      return 2'd1;
    if (writes(m.a3, m.res, r) &&
        ((m.res == RES_ALU) || (m.res == RES_PC8)))
      return 2'd2;
    if (writes(w.a3, w.res, r))
      return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(
    input logic [4:0] r,
    input m_t         m,
    input w_t         w
  );
    if (writes(m.a3, m.res, r) &&
        ((m.res == RES_ALU) || (m.res == RES_PC8)))
      return 2'd2;
    if (writes(w.a3, w.res, r))
      return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    if (tuse_rs0)      tuse_rs = 2'd0;
    else if (tuse_rs1) tuse_rs = 2'd1;
    else               tuse_rs = 2'd3;
  end

  always_comb begin
    if (tuse_rt0)      tuse_rt = 2'd0;
    else if (tuse_rt1) tuse_rt = 2'd1;
    else if (tuse_rt2) tuse_rt = 2'd2;
    else               tuse_rt = 2'd3;
  end

  always_comb begin
    d_in     = '0;
    d_in.a1  = a1_d;
    d_in.a2  = a2_d;
    d_in.a3  = a3_d;
    d_in.res = res_t'(res_d);
  end

  always_comb begin
    md_busy  = (md_cnt != 4'd0);
    stall_rs = hazard(a1_d, tuse_rs, e_q, m_q);
    stall_rt = hazard(a2_d, tuse_rt, e_q, m_q);
    stall_md = md_d && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  always_comb begin
    fwd_rs_d = sel_d(a1_d, e_q, m_q, w_q);
    fwd_rt_d = sel_d(a2_d, e_q, m_q, w_q);
    fwd_rs_e = sel_e(e_q.a1, m_q, w_q);
    fwd_rt_e = sel_e(e_q.a2, m_q, w_q);
    fwd_rt_m = writes(w_q.a3, w_q.res, m_q.a2);
  end

  // A stalled D instruction leaves a bubble (res = NW) in E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q    <= stall ? '0 : d_in;
      m_q.a2 <= e_q.a2;
      m_q.a3 <= e_q.a3;
      m_q.res <= e_q.res;
      w_q.a3 <= m_q.a3;
      w_q.res <= m_q.res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (md_start_d && !stall)
      md_cnt <= md_div_d ? 4'd10 : 4'd5;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed D-stage vectors,
// expected selects queued per cycle and checked by a monitor.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tuse_rs0 = 0, tuse_rs1 = 0;
  logic       tuse_rt0 = 0, tuse_rt1 = 0, tuse_rt2 = 0;
  logic [4:0] a1_d = 0, a2_d = 0, a3_d = 0;
  logic [1:0] res_d = 0;
  logic       md_d = 0, md_start_d = 0, md_div_d = 0;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .tuse_rs0(tuse_rs0), .tuse_rs1(tuse_rs1),
    .tuse_rt0(tuse_rt0), .tuse_rt1(tuse_rt1), .tuse_rt2(tuse_rt2),
    .a1_d(a1_d), .a2_d(a2_d), .a3_d(a3_d), .res_d(res_d),
    .md_d(md_d), .md_start_d(md_start_d), .md_div_d(md_div_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  typedef struct packed {
    logic       rs0, rs1, rt0, rt1, rt2;
    logic [4:0] a1, a2, a3;
    logic [1:0] res;
    logic       md, st, dv;
  } din_t;

  localparam logic [1:0] NW = 2'd0, ALU = 2'd1, DM = 2'd2, PC8 = 2'd3;
  localparam din_t        N = '0;
  localparam logic [10:0] Z = '0;

  logic [10:0] exp_q[$];
  string       nm_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] got;

  assign got = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
                fwd_rt_m, md_busy};

  function automatic logic [10:0] ex(
    input logic s, input logic [1:0] rsd, rtd, rse, rte,
    input logic rtm, busy);
    return {s, rsd, rtd, rse, rte, rtm, busy};
  endfunction

  function automatic din_t wr(input logic [4:0] a3,
                              input logic [1:0] res);
    din_t d = '0;
    d.a3 = a3;
    d.res = res;
    return d;
  endfunction

  function automatic din_t rd(input logic rs0, rs1, rt0, rt1, rt2,
                              input logic [4:0] a1, a2);
    din_t d = '0;
    {d.rs0, d.rs1, d.rt0, d.rt1, d.rt2} = {rs0, rs1, rt0, rt1, rt2};
    d.a1 = a1;
    d.a2 = a2;
    return d;
  endfunction

  function automatic din_t mdo(input logic st, dv);
    din_t d = '0;
    d.md = 1'b1;
    d.st = st;
    d.dv = dv;
    return d;
  endfunction

  task automatic step(input din_t d, input logic rst_v,
                      input logic [10:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rst_v;
    {tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2} =
      {d.rs0, d.rs1, d.rt0, d.rt1, d.rt2};
    a1_d = d.a1;
    a2_d = d.a2;
    a3_d = d.a3;
    res_d = d.res;
    md_d = d.md;
    md_start_d = d.st;
    md_div_d = d.dv;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [10:0] want;
    string       nm;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (stall,rsd,rtd,rse,rte,rtm,busy)",
                 nm, got, want);
      end
    end
  end

  initial begin
    din_t rdr;
    din_t mflo;
    step(N, 1, Z, "reset");
    step(wr(8, DM), 0, Z, "lw_issue");
    rdr = rd(0, 1, 0, 0, 0, 8, 0);
    rdr.a3 = 10;
    rdr.res = ALU;
    step(rdr, 0, ex(1, 0, 0, 0, 0, 0, 0), "loaduse_stall");
    step(rdr, 0, Z, "loaduse_release");
    step(N, 0, ex(0, 0, 0, 3, 0, 0, 0), "loaduse_fwd_e");
    step(N, 0, Z, "loaduse_drain");
    step(wr(9, ALU), 0, Z, "alu_issue");
    step(rd(1, 0, 0, 0, 0, 9, 0), 0, ex(1, 0, 0, 0, 0, 0, 0), "br_stall");
    step(rd(1, 0, 0, 0, 0, 9, 0), 0, ex(0, 2, 0, 0, 0, 0, 0), "br_fwd_d");
    step(N, 0, ex(0, 0, 0, 3, 0, 0, 0), "br_fwd_e");
    step(wr(31, PC8), 0, Z, "jal_issue");
    step(rd(1, 0, 0, 1, 0, 31, 31), 0, ex(0, 1, 1, 0, 0, 0, 0), "jal_fwd_d");
    step(N, 0, ex(0, 0, 0, 2, 2, 0, 0), "jal_fwd_e");
    step(N, 0, ex(0, 0, 0, 0, 0, 1, 0), "jal_fwd_m");
    step(wr(0, ALU), 0, Z, "r0_issue");
    step(rd(1, 0, 1, 0, 0, 0, 0), 0, Z, "r0_no_hazard");
    step(wr(5, DM), 0, Z, "lw5_issue");
    step(rd(0, 0, 0, 0, 1, 0, 5), 0, Z, "sw_no_stall");
    step(rd(0, 0, 1, 0, 0, 0, 5), 0, ex(1, 0, 0, 0, 0, 0, 0), "rt_m_stall");
    step(rd(0, 0, 1, 0, 0, 0, 5), 0, ex(0, 0, 3, 0, 0, 1, 0), "rt_w_fwd");
    step(N, 0, Z, "rt_drain");
    step(mdo(1, 1), 0, Z, "div_issue");
    mflo = mdo(0, 0);
    mflo.a3 = 12;
    mflo.res = ALU;
    for (int i = 0; i < 10; i++)
      step(mflo, 0, ex(1, 0, 0, 0, 0, 0, 1), "div_stall");
    step(mflo, 0, Z, "div_done");
    step(rd(1, 0, 0, 0, 0, 12, 0), 0, ex(1, 0, 0, 0, 0, 0, 0), "mflo_in_e");
    step(rd(1, 0, 0, 0, 0, 12, 0), 0, ex(0, 2, 0, 0, 0, 0, 0), "mflo_fwd_m");
    step(mdo(1, 0), 0, ex(0, 0, 0, 3, 0, 0, 0), "mult_issue");
    for (int i = 0; i < 5; i++)
      step(mdo(1, 1), 0, ex(1, 0, 0, 0, 0, 0, 1), "blocked_start");
    step(mdo(0, 0), 0, Z, "mult_done");
    step(mdo(1, 1), 0, Z, "div2_issue");
    for (int i = 0; i < 6; i++)
      step(N, 0, ex(0, 0, 0, 0, 0, 0, 1), "div2_busy");
    step(wr(7, DM), 0, ex(0, 0, 0, 0, 0, 0, 1), "lw7_busy");
    rdr = rd(0, 1, 0, 0, 0, 7, 0);
    rdr.md = 1'b1;
    step(rdr, 1, Z, "async_reset");
    step(rdr, 1, Z, "reset_hold");
    step(rdr, 0, Z, "post_reset");
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-003 tuse_rs0, tuse_rs1  input  1 each  D-stage instruction reads rs in D / in E.
REQ-004 tuse_rt0, tuse_rt1, tuse_rt2  input  1 each  D-stage instruction reads rt in D / in E / in M.
REQ-005 a1_d, a2_d  input  5 each  D-stage rs and rt register numbers.
REQ-006 a3_d  input  5  D-stage destination register.
REQ-007 res_d  input  2  D-stage result source: NW=00, ALU=01, DM=10, PC8=11.
REQ-008 md_d  input  1  D-stage instruction uses the multiply/divide unit.
REQ-009 md_start_d  input  1  D-stage instruction starts a multiply/divide operation.
REQ-010 md_div_d  input  1  qualifies md_start_d: 1 = div/divu, 0 = mult/multu/msub.
REQ-011 stall  output  1  freeze PC and the IF/ID register; insert a bubble into E.
REQ-012 fwd_rs_d, fwd_rt_d  output  2 each  D-stage operand source: 0 = RF, 1 = E, 2 = M, 3 = W.
REQ-013 fwd_rs_e, fwd_rt_e  output  2 each  E-stage operand source: 0 = ID/EX register, 2 = M, 3 = W (1 is never driven).
REQ-014 fwd_rt_m  output  1  M-stage store data source: 0 = EX/MEM register, 1 = W.
REQ-015 md_busy  output  1  multiply/divide unit is busy.

Function
REQ-016 Internal pipeline registers SHALL be: E holds {a1, a2, a3, res}; M holds {a2, a3, res}; W holds {a3, res}.
REQ-017 Every edge: M <= E and W <= M.
  - E <= D-stage fields when stall = 0.
  - E <= bubble (a1 = a2 = a3 = 0, res = NW) when stall = 1.
REQ-018 A stage "writes r" when its a3 == r, r != 0, and its res != NW.
REQ-019 Tnew in E: ALU = 1, DM = 2, PC8 = 0. Tnew in M: DM = 1, all others 0. Tnew in W: 0.
REQ-020 The rs stall term is asserted when, for r = a1_d, any of these holds:
  - tuse_rs0 and E writes r with res_E in {ALU, DM};
  - tuse_rs0 and M writes r with res_M = DM;
  - tuse_rs1 and E writes r with res_E = DM.
REQ-021 The rt stall term uses the same rules with r = a2_d and tuse_rt0 / tuse_rt1.
  - tuse_rt2 never causes a stall.
REQ-022 md stall = md_d and (md_busy or md_cnt != 0).
REQ-023 stall = rs stall OR rt stall OR md stall; stall is combinational and depends on current inputs and state only.
REQ-024 D-stage forwarding priority for fwd_rs_d / fwd_rt_d is, first match wins:
  - E writes r with res_E = PC8 -> 1;
  - M writes r with res_M in {ALU, PC8} -> 2;
  - W writes r -> 3;
  - otherwise 0.
REQ-025 E-stage forwarding uses a1_E / a2_E and the order M (res in {ALU, PC8}) -> 2, then W -> 3, else 0.
REQ-026 fwd_rt_m = 1 iff W writes a2_M.
REQ-027 Register 0 is never forwarded and never causes a stall.
REQ-028 md_cnt is a 4-bit counter, md_busy = (md_cnt != 0).
  - On an edge where md_start_d = 1 and stall = 0, md_cnt <= 5 for mult or 10 for div.
  - Otherwise, if md_cnt != 0, md_cnt <= md_cnt - 1.
  - A start blocked by stall does not load the counter.
REQ-029 A new start cannot coincide with md_cnt != 0, because it is itself stalled by REQ-022.
  - No reload or overlap case exists.

Reset
REQ-030 While reset is high, all E/M/W registers are cleared (a1 = a2 = a3 = 0, res = NW) and md_cnt = 0, asynchronously.
  - Consequently stall = 0, all forwarding selects = 0, and md_busy = 0.
REQ-031 A reset asserted mid-operation aborts any multiply/divide count and discards in-flight destination tracking.

Verification
REQ-032 Load-use: E = {a3 = 8, res = DM}, D with tuse_rs1 = 1 and a1_d = 8 -> stall = 1 for 1 cycle, E becomes a bubble, then fwd_rs_e = 3 on the following cycle.
REQ-033 Branch after ALU: E = {a3 = 9, res = ALU}, D with tuse_rs0 = 1 and a1_d = 9 -> stall = 1 for 1 cycle, then fwd_rs_d = 2.
REQ-034 jal, then a D-stage tuse_rs0 read of r31: res_E = PC8, a3_E = 31 -> stall = 0, fwd_rs_d = 1.
REQ-035 div issued (md_start_d = 1, md_div_d = 1), then a D-stage mflo (md_d = 1) -> stall held for exactly 10 cycles, md_busy falls, and the mflo advances.
REQ-036 a3 = 0 with res = ALU in E, and D reads $0 with tuse_rs0 -> stall = 0, fwd_rs_d = 0.
REQ-037 Reset asserted while md_cnt = 3 and E holds a DM write -> md_busy = 0 and stall = 0 immediately, without waiting for a clock edge.
